// File: rtl/gps_ca_pkg.sv
// Shared constants, FSM state type and G2 phase-select table for the C/A generator.
package gps_ca_pkg;

    localparam int unsigned CA_LEN  = 1023;
    localparam int unsigned PHASE_W = 10;
    localparam int unsigned LFSR_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SLEW = 2'd2
    } state_t;

    // {tapA, tapB} G2 stage pairs (stage numbers 1..10), indexed by PRN-1.
    localparam logic [7:0] G2_TAP_TABLE [32] = '{
        8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
        8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
        8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
        8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
    };

endpackage

// File: rtl/ca_gold_lfsr.sv
// G1/G2 Gold-code register pair with PRN-selected G2 phase taps.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   advance     shift both registers one chip
//   restart     latch prn and reload both registers with all ones
//   prn         satellite index 0..31 (sampled on restart)
//   chip        current Gold-code chip (combinational from registers)
module ca_gold_lfsr
    import gps_ca_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       restart,
    input  logic [4:0] prn,
    output logic       chip
);

    // Register bit k-1 holds polynomial stage k.
    logic [LFSR_W-1:0] g1;
    logic [LFSR_W-1:0] g2;
    logic [4:0]        prn_q;
    logic [3:0]        tap_a;
    logic [3:0]        tap_b;
    logic [3:0]        idx_a;
    logic [3:0]        idx_b;

    assign {tap_a, tap_b} = G2_TAP_TABLE[prn_q];
    assign idx_a = tap_a - 4'd1;
    assign idx_b = tap_b - 4'd1;
    assign chip  = g1[9] ^ g2[idx_a] ^ g2[idx_b];

    // G1 = 1+x^3+x^10, G2 = 1+x^2+x^3+x^6+x^8+x^9+x^10; shift left, feed stage 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prn_q <= '0;
            g1    <= '1;
            g2    <= '1;
        end else if (restart) begin
            prn_q <= prn;
            g1    <= '1;
            g2    <= '1;
        end else if (advance) begin
            g1 <= {g1[8:0], g1[2] ^ g1[9]};
            g2 <= {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
        end
    end

endmodule

// File: rtl/ca_code_gen_epl.sv
// GPS L1 C/A code generator for one tracking channel with early/prompt/late
// replicas, PRN reload, code-phase slew handshake and code-epoch strobe.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   enable            chip strobe from the code NCO
//   load, prn         restart the code at phase 0 for a new PRN
//   slew_req/chips    delay the code by slew_chips chips (RUN only)
//   slew_done, busy   slew completion pulse and in-progress flag
//   code_phase, epoch chip index of code_early and 1022->0 wrap pulse
//   code_early/prompt/late  replicas spaced SPACING chips apart
module ca_code_gen_epl
    import gps_ca_pkg::*;
#(
    parameter int unsigned SPACING = 1,
    parameter int unsigned SLEW_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [4:0]        prn,
    input  logic              slew_req,
    input  logic [SLEW_W-1:0] slew_chips,
    output logic              slew_done,
    output logic              busy,
    output logic [9:0]        code_phase,
    output logic              epoch,
    output logic              code_early,
    output logic              code_prompt,
    output logic              code_late
);

    localparam int unsigned LINE_W = 2 * SPACING;

    state_t            state;
    logic [SLEW_W-1:0] slew_cnt;
    logic [LINE_W-1:0] line;
    logic              chip;
    logic              advance;

    // Generator only moves on RUN strobes; load takes priority over enable.
    assign advance = (state == RUN) && enable && !load;

    ca_gold_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .restart (load),
        .prn     (prn),
        .chip    (chip)
    );

    // Replicas read 0 while idle so a reset channel presents a quiet output.
    assign code_early  = chip & (state != IDLE);
    assign code_prompt = line[SPACING-1];
    assign code_late   = line[LINE_W-1];

    // Control FSM with phase counter, delay line, slew counter and strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            code_phase <= '0;
            line       <= '0;
            slew_cnt   <= '0;
            slew_done  <= 1'b0;
            epoch      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            slew_done <= 1'b0;
            epoch     <= 1'b0;
            if (load) begin
                state      <= RUN;
                code_phase <= '0;
                line       <= '0;
                slew_cnt   <= '0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    RUN: begin
                        if (enable) begin
                            line <= {line[LINE_W-2:0], code_early};
                            if (code_phase == PHASE_W'(CA_LEN - 1)) begin
                                code_phase <= '0;
                                epoch      <= 1'b1;
                            end else begin
                                code_phase <= code_phase + PHASE_W'(1);
                            end
                        end
                        if (slew_req) begin
                            slew_cnt <= slew_chips;
                            state    <= SLEW;
                            busy     <= 1'b1;
                        end
                    end
                    SLEW: begin
                        // A zero-length slew completes without consuming a strobe.
                        if (slew_cnt == '0) begin
                            state     <= RUN;
                            busy      <= 1'b0;
                            slew_done <= 1'b1;
                        end else if (enable) begin
                            slew_cnt <= slew_cnt - SLEW_W'(1);
                            if (slew_cnt == SLEW_W'(1)) begin
                                state     <= RUN;
                                busy      <= 1'b0;
                                slew_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
